// File: rtl/mem_responder.sv
// Line-granular memory responder for a cache: fixed-latency IDLE/BUSY/READY handshake.
// Optional protocol checker (proto_err port) enabled by defining MEM_PROTO_CHECK_EN.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH_W = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready
`ifdef MEM_PROTO_CHECK_EN
  ,
  output logic         proto_err
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

  state_t               state, state_next;
  logic [7:0]           cnt;
  logic [DEPTH_W-1:0]   line;
  logic [127:0]         wdata_q;
  logic                 op_write;
  logic [127:0]         store [0:(1<<DEPTH_W)-1];
  logic                 one_req;
  logic                 done;
  logic                 unused_addr_hi;

  assign one_req        = mem_read ^ mem_write;
  assign done           = (state == BUSY) && (cnt == '0);
  assign unused_addr_hi = ^mem_addr[27:DEPTH_W];

  always_ff @(posedge clk) begin
    if (proc_reset) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (one_req) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = READY;
      READY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == READY);
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      cnt       <= '0;
      mem_rdata <= '0;
    end else begin
      if (state == IDLE && one_req)
        cnt <= 8'(LATENCY - 1);
      else if (state == BUSY && cnt != '0)
        cnt <= cnt - 8'd1;
      if (done && !op_write)
        mem_rdata <= store[line];
    end
  end

  // Request fields are only meaningful while BUSY, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && one_req) begin
      line     <= mem_addr[DEPTH_W-1:0];
      wdata_q  <= mem_wdata;
      op_write <= mem_write;
    end
  end

  // Reset in the commit cycle aborts the write before it reaches storage.
  always_ff @(posedge clk) begin
    if (!proc_reset && done && op_write)
      store[line] <= wdata_q;
  end

`ifdef MEM_PROTO_CHECK_EN
  logic [27:0] addr_q;
  logic        held_req;

  assign held_req = op_write ? mem_write : mem_read;

  always_ff @(posedge clk) begin
    if (state == IDLE && one_req)
      addr_q <= mem_addr;
  end

  always_ff @(posedge clk) begin
    if (proc_reset)
      proto_err <= 1'b0;
    else if ((state == IDLE && mem_read && mem_write) ||
             (state == BUSY && (!held_req || mem_addr != addr_q)))
      proto_err <= 1'b1;
  end
`endif

endmodule
